obi_master_pipelined: RTL and testbench
=======================================

// Module: obi_master_pipelined
// PURPOSE
//  OBI v1.x manager, successor to the single-transfer master. Accepts controller requests through a
//  req/gnt handshake and keeps up to MAX_OUTSTANDING transfers in flight on the OBI bus. Returns
//  responses in order through a valid/ready port with backpressure. Counts bus errors and flags
//  protocol violations. Sits between a core/DMA controller and an OBI crossbar/subordinate.
// PARAMETERS
//  ADDR_WIDTH      32  address width, 32 or 64
//  DATA_WIDTH      32  data width, 32 or 64; BE width = DATA_WIDTH/8
//  MAX_OUTSTANDING 4   max transfers held (A-register + issued, unanswered), 1..16
//  ERR_CNT_WIDTH   8   width of saturating error counter
// PORTS
//  clk_i            in   1            clock
//  reset_ni         in   1            async active-low reset
//  ctrl_req_i       in   1            controller request
//  ctrl_gnt_o       out  1            request accepted this cycle
//  ctrl_we_i        in   1            1 = write
//  ctrl_be_i        in   DATA_WIDTH/8 byte enables
//  ctrl_addr_i      in   ADDR_WIDTH   address
//  ctrl_wdata_i     in   DATA_WIDTH   write data
//  ctrl_rvalid_o    out  1            response valid
//  ctrl_rready_i    in   1            controller accepts response
//  ctrl_rdata_o     out  DATA_WIDTH   read data (undefined for writes, driven 0)
//  ctrl_err_o       out  1            response error
//  obi_req_o/obi_gnt_i  out/in 1      OBI A-channel handshake
//  obi_addr_o       out  ADDR_WIDTH   OBI address
//  obi_we_o         out  1            OBI write enable
//  obi_be_o         out  DATA_WIDTH/8 OBI byte enables
//  obi_wdata_o      out  DATA_WIDTH   OBI write data
//  obi_rvalid_i/obi_rready_o in/out 1 OBI R-channel handshake
//  obi_rdata_i      in   DATA_WIDTH   OBI read data
//  obi_err_i        in   1            OBI error
//  outstanding_o    out  $clog2(MAX_OUTSTANDING+1)  current slot count
//  err_cnt_o        out  ERR_CNT_WIDTH  saturating count of err responses
//  proto_err_o      out  1            sticky: rvalid with nothing issued
// BEHAVIOUR
//  Reset: all outputs 0; slots_q=0, A-reg empty, R-reg empty, err_cnt=0, proto_err=0.
//  A-phase FSM {A_IDLE, A_ADDR}; one A-register (a_vld_q, addr, we, be, wdata).
//  - ctrl_gnt_o = (slots_q < MAX_OUTSTANDING) && (!a_vld_q || obi_gnt_i). Purely combinational.
//  - Accepted request is latched; A_ADDR next cycle, obi_req_o=1 (latency 1 cycle ctrl->bus).
//  - While obi_req_o=1 and !obi_gnt_i: addr/we/be/wdata held stable, req never dropped (OBI R-3).
//  - obi_gnt_i && new accept same cycle: reload A-register, stay A_ADDR (back-to-back, 1 xfer/clk).
//  - obi_gnt_i, no accept: A_IDLE, obi_req_o=0, obi_* data outputs hold last value.
//  Slot accounting: slots_q +1 on ctrl accept, -1 on OBI R handshake; both same cycle -> unchanged.
//  - Never exceeds MAX_OUTSTANDING; issued = slots_q - a_vld_q.
//  R-phase: one-entry response register r_vld_q.
//  - obi_rready_o = !r_vld_q || ctrl_rready_i; capture rdata/err on obi_rvalid_i && obi_rready_o.
//  - ctrl_rvalid_o = r_vld_q (latency 1 cycle bus->ctrl); cleared on ctrl_rready_i unless refilled.
//  - Responses in issue order (no IDs).
//  - rdata captured as 0 for write responses.
//  - obi_rvalid_i while issued==0: not captured, slots unchanged, proto_err_o set (sticky until reset).
//  err_cnt_o increments on each captured err response; saturates at 2**ERR_CNT_WIDTH-1.
//  Async reset mid-transfer: all state cleared immediately; in-flight responses are subsequently
//  flagged as proto_err (documented, system must reset both sides together).
// STRUCTURE
//  Package obi_master_pkg: a_state_e enum, a_chan_t/r_chan_t structs parametrised by widths
//  (via typedef in module), constants for MAX_OUTSTANDING limit.
//  Sub-module obi_rsp_reg: one-entry valid/ready response buffer (rdata, err), reused elsewhere.
// TESTING
//  1 single read: ctrl req addr=0x100, gnt 1 clk later, rvalid rdata=0xDEADBEEF -> ctrl_rdata_o=0xDEADBEEF, 1 clk after
//  2 burst: 4 back-to-back writes, obi_gnt_i=1, rvalid withheld -> 4 A handshakes on consecutive clks;
//    5th ctrl_gnt_o=0; outstanding_o=4
//  3 stall: obi_gnt_i=0 for 5 clks -> obi_addr/we/be/wdata stable, obi_req_o stays 1
//  4 backpressure: ctrl_rready_i=0, two rvalids -> first held in R-reg, obi_rready_o=0 until drained,
//    order kept
//  5 errors: 300 err responses with ERR_CNT_WIDTH=8 -> err_cnt_o=255; ctrl_err_o=1 on each
//  6 boundaries: obi_rvalid_i with outstanding_o=0 -> proto_err_o=1, no ctrl_rvalid_o;
//    reset_ni low mid-burst -> all outputs 0 same cycle

Source files
------------

// File: rtl/obi_master_pkg.sv
// obi_master_pkg: shared types and limits for the pipelined OBI manager
package obi_master_pkg;
  typedef enum logic {A_IDLE = 1'b0, A_ADDR = 1'b1} a_state_e;
  localparam int unsigned MAX_OUTSTANDING_LIMIT = 16;
endpackage

// File: rtl/obi_rsp_reg.sv
// obi_rsp_reg: one-entry valid/ready response buffer holding rdata and err
module obi_rsp_reg #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_WIDTH-1:0] in_rdata_i,
  input  logic                  in_err_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] out_rdata_o,
  output logic                  out_err_o
);
  logic                  vld_q, vld_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  fire;

  // accept a new entry whenever empty or being drained this cycle
  always_comb begin
    in_ready_o  = !vld_q || out_ready_i;
    fire        = in_valid_i && in_ready_o;
    vld_d       = fire ? 1'b1 : (out_ready_i ? 1'b0 : vld_q);
    rdata_d     = fire ? in_rdata_i : rdata_q;
    err_d       = fire ? in_err_i : err_q;
    out_valid_o = vld_q;
    out_rdata_o = rdata_q;
    out_err_o   = err_q;
  end

  // entry storage
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q   <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      vld_q   <= vld_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: rtl/obi_master_pipelined.sv
// obi_master_pipelined: OBI manager keeping several transfers in flight with in-order responses
module obi_master_pipelined
  import obi_master_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int ERR_CNT_WIDTH   = 8
) (
  input  logic                                 clk_i,
  input  logic                                 reset_ni,
  input  logic                                 ctrl_req_i,
  output logic                                 ctrl_gnt_o,
  input  logic                                 ctrl_we_i,
  input  logic [DATA_WIDTH/8-1:0]              ctrl_be_i,
  input  logic [ADDR_WIDTH-1:0]                ctrl_addr_i,
  input  logic [DATA_WIDTH-1:0]                ctrl_wdata_i,
  output logic                                 ctrl_rvalid_o,
  input  logic                                 ctrl_rready_i,
  output logic [DATA_WIDTH-1:0]                ctrl_rdata_o,
  output logic                                 ctrl_err_o,
  output logic                                 obi_req_o,
  input  logic                                 obi_gnt_i,
  output logic [ADDR_WIDTH-1:0]                obi_addr_o,
  output logic                                 obi_we_o,
  output logic [DATA_WIDTH/8-1:0]              obi_be_o,
  output logic [DATA_WIDTH-1:0]                obi_wdata_o,
  input  logic                                 obi_rvalid_i,
  output logic                                 obi_rready_o,
  input  logic [DATA_WIDTH-1:0]                obi_rdata_i,
  input  logic                                 obi_err_i,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
  output logic [ERR_CNT_WIDTH-1:0]             err_cnt_o,
  output logic                                 proto_err_o
);
  localparam int BW = DATA_WIDTH / 8;
  localparam int SW = $clog2(MAX_OUTSTANDING + 1);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic                  we;
    logic [BW-1:0]         be;
    logic [DATA_WIDTH-1:0] wdata;
  } a_chan_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] rdata;
    logic                  err;
  } r_chan_t;

  if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > MAX_OUTSTANDING_LIMIT) begin : g_bad_max
    $error("MAX_OUTSTANDING out of range");
  end

  a_state_e                 a_state_q, a_state_d;
  a_chan_t                  a_q, a_d;
  logic [SW-1:0]            slots_q, slots_d, issued, push_idx;
  logic [MAX_OUTSTANDING-1:0] we_q, we_d, we_pop;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
  logic                     proto_err_q, proto_err_d;
  logic                     a_vld, accept, a_hs, r_in_vld, r_in_rdy, r_hs;
  r_chan_t                  r_in;

  // handshake decisions; gnt and rready are forced low while reset is held
  always_comb begin
    a_vld        = a_state_q == A_ADDR;
    issued       = slots_q - SW'(a_vld);
    ctrl_gnt_o   = reset_ni && (slots_q < SW'(MAX_OUTSTANDING)) && (!a_vld || obi_gnt_i);
    accept       = ctrl_req_i && ctrl_gnt_o;
    a_hs         = a_vld && obi_gnt_i;
    r_in_vld     = obi_rvalid_i && (issued != '0);
    obi_rready_o = reset_ni && r_in_rdy;
    r_hs         = r_in_vld && obi_rready_o;
    r_in.rdata   = we_q[0] ? '0 : obi_rdata_i;
    r_in.err     = obi_err_i;
  end

  // A-phase next state: a new accept keeps the request up, a grant alone retires it
  always_comb begin
    a_state_d = accept ? A_ADDR : (a_hs ? A_IDLE : a_state_q);
  end

  // A-phase outputs straight from the A-register so they hold while stalled
  always_comb begin
    obi_req_o   = a_vld;
    obi_addr_o  = a_q.addr;
    obi_we_o    = a_q.we;
    obi_be_o    = a_q.be;
    obi_wdata_o = a_q.wdata;
  end

  // A-register load, slot count, in-order write-flag queue, error tracking
  always_comb begin
    a_d         = accept ? a_chan_t'{addr: ctrl_addr_i, we: ctrl_we_i, be: ctrl_be_i,
                                     wdata: ctrl_wdata_i} : a_q;
    slots_d     = slots_q + SW'(accept) - SW'(r_hs);
    we_pop      = r_hs ? we_q >> 1 : we_q;
    push_idx    = issued - SW'(r_hs);
    we_d        = a_hs ? (we_pop & ~(MAX_OUTSTANDING'(1) << push_idx)) |
                         (MAX_OUTSTANDING'(a_q.we) << push_idx) : we_pop;
    err_cnt_d   = (r_hs && obi_err_i && err_cnt_q != '1) ? err_cnt_q + ERR_CNT_WIDTH'(1) : err_cnt_q;
    proto_err_d = proto_err_q || (obi_rvalid_i && issued == '0);
  end

  // state register
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      a_state_q   <= A_IDLE;
      a_q         <= '0;
      slots_q     <= '0;
      we_q        <= '0;
      err_cnt_q   <= '0;
      proto_err_q <= 1'b0;
    end else begin
      a_state_q   <= a_state_d;
      a_q         <= a_d;
      slots_q     <= slots_d;
      we_q        <= we_d;
      err_cnt_q   <= err_cnt_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign outstanding_o = slots_q;
  assign err_cnt_o     = err_cnt_q;
  assign proto_err_o   = proto_err_q;

  obi_rsp_reg #(.DATA_WIDTH(DATA_WIDTH)) u_rsp (
    .clk_i       (clk_i),
    .rst_ni      (reset_ni),
    .in_valid_i  (r_in_vld),
    .in_ready_o  (r_in_rdy),
    .in_rdata_i  (r_in.rdata),
    .in_err_i    (r_in.err),
    .out_valid_o (ctrl_rvalid_o),
    .out_ready_i (ctrl_rready_i),
    .out_rdata_o (ctrl_rdata_o),
    .out_err_o   (ctrl_err_o)
  );
endmodule

// File: tb/tb_obi_master_pipelined.sv
// tb_obi_master_pipelined: scenario tasks plus an in-order response scoreboard
module tb_obi_master_pipelined;
  logic        clk, reset_ni;
  logic        ctrl_req, ctrl_gnt, ctrl_we, ctrl_rvalid, ctrl_rready, ctrl_err;
  logic [3:0]  ctrl_be, obi_be;
  logic [31:0] ctrl_addr, ctrl_wdata, ctrl_rdata;
  logic        obi_req, obi_gnt, obi_we, obi_rvalid, obi_rready, obi_err;
  logic [31:0] obi_addr, obi_wdata, obi_rdata;
  logic [2:0]  outstanding;
  logic [7:0]  err_cnt;
  logic        proto_err;
  int          errors = 0;
  int          checks = 0;
  logic [32:0] exp_q[$];
  logic [32:0] exp_rsp;

  obi_master_pipelined dut (
    .clk_i(clk), .reset_ni(reset_ni),
    .ctrl_req_i(ctrl_req), .ctrl_gnt_o(ctrl_gnt), .ctrl_we_i(ctrl_we), .ctrl_be_i(ctrl_be),
    .ctrl_addr_i(ctrl_addr), .ctrl_wdata_i(ctrl_wdata), .ctrl_rvalid_o(ctrl_rvalid),
    .ctrl_rready_i(ctrl_rready), .ctrl_rdata_o(ctrl_rdata), .ctrl_err_o(ctrl_err),
    .obi_req_o(obi_req), .obi_gnt_i(obi_gnt), .obi_addr_o(obi_addr), .obi_we_o(obi_we),
    .obi_be_o(obi_be), .obi_wdata_o(obi_wdata), .obi_rvalid_i(obi_rvalid),
    .obi_rready_o(obi_rready), .obi_rdata_i(obi_rdata), .obi_err_i(obi_err),
    .outstanding_o(outstanding), .err_cnt_o(err_cnt), .proto_err_o(proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard: every response accepted by the controller must match the oldest expectation
  always @(negedge clk) begin
    if (reset_ni && ctrl_rvalid && ctrl_rready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected: got rdata=%h err=%b, required no response", ctrl_rdata, ctrl_err);
      end else begin
        exp_rsp = exp_q.pop_front();
        if ({ctrl_rdata, ctrl_err} !== exp_rsp) begin
          errors++;
          $display("FAIL rsp_data: got rdata=%h err=%b, required rdata=%h err=%b",
                   ctrl_rdata, ctrl_err, exp_rsp[32:1], exp_rsp[0]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_ni = 1'b1; ctrl_req = 0; ctrl_we = 0; ctrl_be = 0; ctrl_addr = 0; ctrl_wdata = 0;
    ctrl_rready = 1; obi_gnt = 0; obi_rvalid = 0; obi_rdata = 0; obi_err = 0;
    #1 reset_ni = 1'b0;
    @(negedge clk);
    checks++;
    if ({ctrl_gnt, obi_req, obi_rready, ctrl_rvalid, outstanding, err_cnt, proto_err, obi_addr,
         obi_we, obi_be, obi_wdata, ctrl_rdata, ctrl_err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got gnt=%b req=%b rready=%b rvalid=%b out=%0d errcnt=%0d proto=%b, required all 0",
               ctrl_gnt, obi_req, obi_rready, ctrl_rvalid, outstanding, err_cnt, proto_err);
    end
    step();
    step();
    reset_ni = 1'b1;
    @(negedge clk);
    checks++;
    if (ctrl_gnt !== 1'b1) begin
      errors++;
      $display("FAIL gnt_after_reset: got %b, required 1", ctrl_gnt);
    end
  endtask

  task automatic test_single_read();
    step();
    ctrl_req = 1; ctrl_we = 0; ctrl_addr = 32'h100; ctrl_be = 4'hf;
    @(negedge clk);
    checks++;
    if (ctrl_gnt !== 1'b1) begin errors++; $display("FAIL single_gnt: got %b, required 1", ctrl_gnt); end
    step();
    ctrl_req = 0; obi_gnt = 1;
    @(negedge clk);
    checks++;
    if ({obi_req, obi_addr, obi_we, outstanding} !== {1'b1, 32'h100, 1'b0, 3'd1}) begin
      errors++;
      $display("FAIL single_issue: got req=%b addr=%h we=%b out=%0d, required req=1 addr=100 we=0 out=1",
               obi_req, obi_addr, obi_we, outstanding);
    end
    step();
    obi_gnt = 0; obi_rvalid = 1; obi_rdata = 32'hDEADBEEF; obi_err = 0;
    exp_q.push_back({32'hDEADBEEF, 1'b0});
    @(negedge clk);
    checks++;
    if ({obi_req, obi_rready, ctrl_rvalid} !== 3'b010) begin
      errors++;
      $display("FAIL single_rphase: got req=%b rready=%b rvalid=%b, required 0 1 0", obi_req, obi_rready, ctrl_rvalid);
    end
    step();
    obi_rvalid = 0;
    @(negedge clk);
    checks++;
    if ({ctrl_rvalid, ctrl_rdata, outstanding} !== {1'b1, 32'hDEADBEEF, 3'd0}) begin
      errors++;
      $display("FAIL single_rsp: got rvalid=%b rdata=%h out=%0d, required 1 deadbeef 0", ctrl_rvalid, ctrl_rdata, outstanding);
    end
    step();
    @(negedge clk);
    checks++;
    if (ctrl_rvalid !== 1'b0) begin errors++; $display("FAIL single_drain: got rvalid=%b, required 0", ctrl_rvalid); end
  endtask

  task automatic test_back_to_back();
    step();
    ctrl_req = 1; ctrl_we = 1; ctrl_be = 4'hf; ctrl_addr = 32'h200; ctrl_wdata = 32'hA0; obi_gnt = 1;
    @(negedge clk);
    checks++;
    if (ctrl_gnt !== 1'b1) begin errors++; $display("FAIL burst_gnt0: got %b, required 1", ctrl_gnt); end
    for (int i = 1; i <= 4; i++) begin
      step();
      ctrl_addr = 32'h200 + 32'(4 * i); ctrl_wdata = 32'hA0 + 32'(i);
      @(negedge clk);
      checks++;
      if ({obi_req, obi_addr, obi_wdata, obi_we} !== {1'b1, 32'h200 + 32'(4 * (i - 1)), 32'hA0 + 32'(i - 1), 1'b1}) begin
        errors++;
        $display("FAIL burst_issue%0d: got req=%b addr=%h wdata=%h we=%b, required req=1 addr=%h wdata=%h we=1",
                 i, obi_req, obi_addr, obi_wdata, obi_we, 32'h200 + 32'(4 * (i - 1)), 32'hA0 + 32'(i - 1));
      end
      checks++;
      if (ctrl_gnt !== (i < 4)) begin
        errors++;
        $display("FAIL burst_gnt%0d: got %b, required %b", i, ctrl_gnt, i < 4);
      end
    end
    checks++;
    if (outstanding !== 3'd4) begin errors++; $display("FAIL burst_outstanding: got %0d, required 4", outstanding); end
    step();
    ctrl_req = 0; obi_gnt = 0;
    @(negedge clk);
    checks++;
    if ({obi_req, ctrl_gnt, outstanding} !== {2'b00, 3'd4}) begin
      errors++;
      $display("FAIL burst_full: got req=%b gnt=%b out=%0d, required 0 0 4", obi_req, ctrl_gnt, outstanding);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      obi_rvalid = 1; obi_rdata = 32'hFFFF_FFFF; obi_err = 0;
      exp_q.push_back(33'h0);
    end
    step();
    obi_rvalid = 0;
    step();
    step();
    @(negedge clk);
    checks++;
    if (outstanding !== 3'd0) begin errors++; $display("FAIL burst_drained: got %0d, required 0", outstanding); end
  endtask

  task automatic test_stall();
    step();
    ctrl_req = 1; ctrl_we = 1; ctrl_be = 4'h3; ctrl_addr = 32'h300; ctrl_wdata = 32'hCAFEF00D; obi_gnt = 0;
    step();
    ctrl_req = 0; ctrl_we = 0; ctrl_be = 4'hc; ctrl_addr = 32'hBAD; ctrl_wdata = 32'h0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({obi_req, obi_addr, obi_we, obi_be, obi_wdata} !== {1'b1, 32'h300, 1'b1, 4'h3, 32'hCAFEF00D}) begin
        errors++;
        $display("FAIL stall_hold%0d: got req=%b addr=%h we=%b be=%h wdata=%h, required 1 300 1 3 cafef00d",
                 i, obi_req, obi_addr, obi_we, obi_be, obi_wdata);
      end
      step();
    end
    checks++;
    if (ctrl_gnt !== 1'b0) begin errors++; $display("FAIL stall_gnt: got %b, required 0", ctrl_gnt); end
    obi_gnt = 1;
    step();
    obi_gnt = 0; obi_rvalid = 1; obi_rdata = 32'h12345678; obi_err = 0;
    exp_q.push_back(33'h0);
    step();
    obi_rvalid = 0;
    step();
    step();
  endtask

  task automatic test_backpressure();
    ctrl_rready = 0; ctrl_req = 1; ctrl_we = 0; ctrl_be = 4'hf; ctrl_addr = 32'h400; obi_gnt = 1;
    step();
    ctrl_addr = 32'h404;
    step();
    ctrl_req = 0;
    step();
    obi_gnt = 0; obi_rvalid = 1; obi_rdata = 32'h11111111;
    exp_q.push_back({32'h11111111, 1'b0});
    step();
    obi_rdata = 32'h22222222;
    exp_q.push_back({32'h22222222, 1'b0});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({obi_rready, ctrl_rvalid, ctrl_rdata} !== {2'b01, 32'h11111111}) begin
        errors++;
        $display("FAIL bp_hold%0d: got rready=%b rvalid=%b rdata=%h, required 0 1 11111111",
                 i, obi_rready, ctrl_rvalid, ctrl_rdata);
      end
      step();
    end
    ctrl_rready = 1;
    @(negedge clk);
    checks++;
    if (obi_rready !== 1'b1) begin errors++; $display("FAIL bp_release: got rready=%b, required 1", obi_rready); end
    step();
    obi_rvalid = 0;
    @(negedge clk);
    checks++;
    if ({ctrl_rvalid, ctrl_rdata} !== {1'b1, 32'h22222222}) begin
      errors++;
      $display("FAIL bp_second: got rvalid=%b rdata=%h, required 1 22222222", ctrl_rvalid, ctrl_rdata);
    end
    step();
    @(negedge clk);
    checks++;
    if ({ctrl_rvalid, outstanding} !== {1'b0, 3'd0}) begin
      errors++;
      $display("FAIL bp_empty: got rvalid=%b out=%0d, required 0 0", ctrl_rvalid, outstanding);
    end
  endtask

  task automatic do_xfer(input logic [31:0] addr, input logic [31:0] rdata, input logic err);
    ctrl_req = 1; ctrl_we = 0; ctrl_be = 4'hf; ctrl_addr = addr;
    step();
    ctrl_req = 0; obi_gnt = 1;
    step();
    obi_gnt = 0; obi_rvalid = 1; obi_rdata = rdata; obi_err = err;
    exp_q.push_back({rdata, err});
    step();
    obi_rvalid = 0; obi_err = 0;
  endtask

  task automatic test_errors();
    for (int i = 0; i < 300; i++) begin
      do_xfer(32'h600 + 32'(i), 32'(i) ^ 32'h5A5A_0000, 1'b1);
      if (i == 99) begin
        step();
        @(negedge clk);
        checks++;
        if (err_cnt !== 8'd100) begin errors++; $display("FAIL err_cnt_100: got %0d, required 100", err_cnt); end
        step();
      end
    end
    step();
    step();
    @(negedge clk);
    checks++;
    if (err_cnt !== 8'd255) begin errors++; $display("FAIL err_cnt_sat: got %0d, required 255", err_cnt); end
  endtask

  task automatic test_boundaries();
    step();
    @(negedge clk);
    checks++;
    if ({proto_err, outstanding} !== 4'b0) begin
      errors++;
      $display("FAIL proto_pre: got proto=%b out=%0d, required 0 0", proto_err, outstanding);
    end
    step();
    obi_rvalid = 1; obi_rdata = 32'h55;
    step();
    obi_rvalid = 0;
    @(negedge clk);
    checks++;
    if ({proto_err, ctrl_rvalid, outstanding} !== {2'b10, 3'd0}) begin
      errors++;
      $display("FAIL proto_set: got proto=%b rvalid=%b out=%0d, required 1 0 0", proto_err, ctrl_rvalid, outstanding);
    end
    step();
    step();
    @(negedge clk);
    checks++;
    if (proto_err !== 1'b1) begin errors++; $display("FAIL proto_sticky: got %b, required 1", proto_err); end
    step();
    ctrl_req = 1; ctrl_we = 1; ctrl_be = 4'hf; ctrl_addr = 32'h500; ctrl_wdata = 32'h77; obi_gnt = 0;
    step();
    @(negedge clk);
    checks++;
    if ({obi_req, outstanding} !== {1'b1, 3'd1}) begin
      errors++;
      $display("FAIL midburst_pre: got req=%b out=%0d, required 1 1", obi_req, outstanding);
    end
    #2 reset_ni = 0;
    #1;
    checks++;
    if ({ctrl_gnt, obi_req, obi_rready, ctrl_rvalid, outstanding, err_cnt, proto_err, obi_addr,
         obi_we, obi_be, obi_wdata, ctrl_rdata, ctrl_err} !== '0) begin
      errors++;
      $display("FAIL midburst_reset: got gnt=%b req=%b rready=%b rvalid=%b out=%0d errcnt=%0d proto=%b addr=%h, required all 0",
               ctrl_gnt, obi_req, obi_rready, ctrl_rvalid, outstanding, err_cnt, proto_err, obi_addr);
    end
    ctrl_req = 0;
    step();
    reset_ni = 1;
    @(negedge clk);
    checks++;
    if ({ctrl_gnt, obi_req, outstanding} !== {2'b10, 3'd0}) begin
      errors++;
      $display("FAIL post_reset: got gnt=%b req=%b out=%0d, required 1 0 0", ctrl_gnt, obi_req, outstanding);
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_back_to_back();
    test_stall();
    test_backpressure();
    test_errors();
    test_boundaries();
    step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: got %0d pending responses, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
